fc_stream_mvm: RTL

//  Parametrised streaming fully-connected layer: y = W*x, W is MxN, x is an N-vector and y is an M-vector, all signed T-bit.

---
 rtl/fc_pkg.sv | 49 ++++
 rtl/fc_lane_mac.sv | 62 ++++++
 rtl/fc_stream_mvm.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the streaming fully-connected layer (fc_stream_mvm).
//   fc_state_t  : top-level FSM states (LOAD x vector, MAC a pass, DRAIN a pass).
//   cnt_w()     : counter/address width helper that never returns zero.
//   sat_to_t()  : clamps a sign-extended accumulator value to the signed T-bit range.
// Optional ReLU of the lane outputs is controlled by the FC_STREAM_RELU_EN macro
// (see fc_lane_mac.sv).
package fc_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2
  } fc_state_t;

  // Widest accumulator / data word the saturation helper can handle.
  localparam int FC_ACC_MAX_W = 128;
  localparam int FC_T_MAX_W   = 64;

  // Width of a counter or address that must hold values 0..n-1.
  // Clamped to 1 so that single-value counters still get a real bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp acc (already sign-extended to FC_ACC_MAX_W bits, carrying acc_w
  // meaningful bits) into [-2^(t-1), 2^(t-1)-1]. The caller keeps the low t bits.
  function automatic logic signed [FC_T_MAX_W-1:0] sat_to_t(
    input logic signed [FC_ACC_MAX_W-1:0] acc,
    input int                             acc_w,
    input int                             t
  );
    logic signed [FC_ACC_MAX_W-1:0] one;
    logic signed [FC_ACC_MAX_W-1:0] hi;
    logic signed [FC_ACC_MAX_W-1:0] lo;
    one = FC_ACC_MAX_W'(1);
    hi  = (one <<< (t - 1)) - one;
    lo  = -(one <<< (t - 1));
    if (acc_w <= t) begin
      return acc[FC_T_MAX_W-1:0];
    end else if (acc > hi) begin
      return hi[FC_T_MAX_W-1:0];
    end else if (acc < lo) begin
      return lo[FC_T_MAX_W-1:0];
    end else begin
      return acc[FC_T_MAX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fc_lane_mac.sv
// One multiply-accumulate lane of fc_stream_mvm.
//   clk, rst_n : clock and asynchronous active-low reset (clears the accumulator)
//   clear      : zero the accumulator at the next edge (start of a pass)
//   en         : add w*x into the accumulator at the next edge
//   w, x       : signed T-bit weight and input sample
//   acc_sat    : saturated T-bit view of the accumulator value as it will stand
//                after the coming edge; equal to the stored value whenever
//                clear and en are both low. With FC_STREAM_RELU_EN defined a
//                negative accumulator is reported as zero.
module fc_lane_mac
  import fc_pkg::*;
#(
  parameter int T     = 16,
  parameter int ACC_W = 35
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                en,
  input  logic signed [T-1:0] w,
  input  logic signed [T-1:0] x,
  output logic        [T-1:0] acc_sat
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [2*T-1:0]   prod;

  function automatic logic [T-1:0] post_proc(input logic signed [ACC_W-1:0] a);
    logic signed [FC_ACC_MAX_W-1:0] ext;
    ext = FC_ACC_MAX_W'(a);
`ifdef FC_STREAM_RELU_EN
    if (a[ACC_W-1]) begin
      return '0;
    end
`endif
    return T'(sat_to_t(ext, ACC_W, T));
  endfunction

  always_comb begin
    prod  = (2*T)'(w) * (2*T)'(x);
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Looking at acc_d lets the first word of a pass be registered on the same
  // edge that completes the last accumulate, so DRAIN needs no bubble cycle.
  assign acc_sat = post_proc(acc_d);

endmodule

// File: rtl/fc_stream_mvm.sv
// Streaming fully-connected layer y = W*x (W is MxN, signed T-bit data).
// x arrives one word per input handshake into an N-entry buffer; y is computed
// in M/P passes of P parallel MAC lanes and streamed out one word per output
// handshake. Weights come from an external ROM with one cycle read latency.
// Build option: define FC_STREAM_RELU_EN to clamp negative results to zero.
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   input_valid/ready  : x word handshake, input_data = x[n] for n = 0..N-1
//   output_valid/ready : y word handshake, output_data = y[m] for m = 0..M-1
//   w_addr             : weight ROM address k*N + n (k = pass index)
//   w_data             : ROM word one cycle after w_addr, lane p in [p*T +: T]
module fc_stream_mvm
  import fc_pkg::*;
#(
  parameter int  M     = 16,
  parameter int  N     = 8,
  parameter int  T     = 16,
  parameter int  P     = 2,
  parameter int  ACC_W = 2*T + $clog2(N),
  localparam int AW    = cnt_w((M/P)*N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           input_valid,
  output logic           input_ready,
  input  logic [T-1:0]   input_data,
  output logic           output_valid,
  input  logic           output_ready,
  output logic [T-1:0]   output_data,
  output logic [AW-1:0]  w_addr,
  input  logic [P*T-1:0] w_data
);

  localparam int KN = M / P;        // number of passes per vector
  localparam int CW = cnt_w(N + 1); // cnt runs 0..N in MAC
  localparam int IW = cnt_w(N);     // vector buffer index
  localparam int KW = cnt_w(KN);
  localparam int SW = cnt_w(P);

  if ((M % P) != 0) begin : g_bad_mp
    $error("fc_stream_mvm: M must be a multiple of P");
  end
  if (N < 2) begin : g_bad_n
    $error("fc_stream_mvm: N must be at least 2");
  end
  if ((P < 1) || (P > M)) begin : g_bad_p
    $error("fc_stream_mvm: P must be in 1..M");
  end

  fc_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          input_ready_q, input_ready_d;
  logic          output_valid_q, output_valid_d;
  logic [T-1:0]  output_data_q, output_data_d;

  logic          in_hs;
  logic          out_hs;
  logic          acc_clear;
  logic          mac_en;
  logic          x_rd_en;
  logic [IW-1:0] x_idx;

  logic [T-1:0]  x_mem [N];
  logic [T-1:0]  x_rd_q;
  logic [T-1:0]  lane_sat [P];

  assign in_hs   = input_valid && input_ready_q;
  assign out_hs  = output_valid_q && output_ready;
  // cnt is the write index in LOAD and the read index in MAC cycles 0..N-1.
  assign x_idx   = cnt_q[IW-1:0];
  assign x_rd_en = (state_q == MAC) && (cnt_q < CW'(N));
  // The ROM word and buffered x for index c land one cycle after cycle c.
  assign mac_en  = (state_q == MAC) && (cnt_q != '0);

  // Vector buffer: plain memory with a registered read port.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      x_mem[x_idx] <= input_data;
    end
    if (x_rd_en) begin
      x_rd_q <= x_mem[x_idx];
    end
  end

  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    fc_lane_mac #(
      .T     (T),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (reset),
      .clear   (acc_clear),
      .en      (mac_en),
      .w       (w_data[gi*T +: T]),
      .x       (x_rd_q),
      .acc_sat (lane_sat[gi])
    );
  end

  always_comb begin
    w_addr = AW'(int'(k_q) * N + (x_rd_en ? int'(cnt_q) : 0));
  end

  // Next-state and counter logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    sel_d     = sel_q;
    acc_clear = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (in_hs) begin
          if (cnt_q == CW'(N - 1)) begin
            state_d   = MAC;
            cnt_d     = '0;
            acc_clear = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      MAC: begin
        if (cnt_q == CW'(N)) begin
          state_d = DRAIN;
          cnt_d   = '0;
          sel_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (sel_q == SW'(P - 1)) begin
            sel_d = '0;
            if (k_q == KW'(KN - 1)) begin
              k_d     = '0;
              state_d = LOAD;
            end else begin
              // Same x, next block of P rows.
              k_d       = k_q + 1'b1;
              state_d   = MAC;
              acc_clear = 1'b1;
            end
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
        k_d     = '0;
        sel_d   = '0;
      end
    endcase
  end

  // Registered outputs follow the next state. In DRAIN the lane accumulators
  // are idle, so re-selecting the same lane keeps output_data stable.
  always_comb begin
    input_ready_d  = (state_d == LOAD);
    output_valid_d = (state_d == DRAIN);
    output_data_d  = output_data_q;
    if (state_d == DRAIN) begin
      output_data_d = lane_sat[sel_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= LOAD;
      cnt_q          <= '0;
      k_q            <= '0;
      sel_q          <= '0;
      input_ready_q  <= 1'b1;
      output_valid_q <= 1'b0;
      output_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      k_q            <= k_d;
      sel_q          <= sel_d;
      input_ready_q  <= input_ready_d;
      output_valid_q <= output_valid_d;
      output_data_q  <= output_data_d;
    end
  end

  assign input_ready  = input_ready_q;
  assign output_valid = output_valid_q;
  assign output_data  = output_data_q;

endmodule
